ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, the next generation of our single-byte mouse receiver. Adds a PS/2 line synchroniser and glitch filter, a timeout derived from clock frequency, selectable parity checking, and a first-word-fall-through FIFO of received bytes with per-byte error status. It sits between the PS/2 pins and the mouse/keyboard master FSMs, which drain it at their own pace.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency
TIMEOUT_US, 2000, maximum gap between PS/2 clock falling edges inside a frame
FILTER_LEN, 8, consecutive equal samples needed before the filtered PS/2 clock changes level (>=2)
FIFO_DEPTH, 4, number of byte entries (power of 2, >=2)
PARITY_EN, 1, 1 = check odd parity; 0 = parity bit ignored and status bit0 always 0

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-low reset
CLK_MOUSE_IN  in  1  raw PS/2 clock line
DATA_MOUSE_IN  in  1  raw PS/2 data line
READ_ENABLE  in  1  1 = accept new frames
POP  in  1  consume FIFO head (ignored when EMPTY)
BYTE_READ  out  8  FIFO head data byte
BYTE_ERROR_CODE  out  2  FIFO head status: bit0 parity error, bit1 stop-bit error
EMPTY  out  1  FIFO empty
FULL  out  1  FIFO full
LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
OVERFLOW  out  1  sticky: a received byte was dropped
TIMEOUT  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (RESET==0 at posedge CLK): FSM IDLE, FIFO cleared; BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, EMPTY=1, FULL=0, LEVEL=0, OVERFLOW=0, TIMEOUT=0; filter levels set to 1 (idle bus). Reset mid-frame discards the partial frame.
- Input path: both lines go through 2-flop synchronisers. The filtered clock changes only after FILTER_LEN consecutive identical synchronised samples. The edge flag is high for one cycle when the filtered clock goes 1->0. Data is sampled from the synchronised data line in the edge cycle.
- TIMEOUT_CYCLES = CLK_FREQ_HZ/1000000*TIMEOUT_US. The counter clears on every edge flag and in IDLE. In any non-IDLE state, when the counter reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, TIMEOUT pulses, and nothing is pushed.
- FSM states:
  - IDLE: edge & data==0 & READ_ENABLE -> DATA, with bit count 0 and status cleared. An edge with data==1 is ignored.
  - DATA: on each edge, shift the bit in LSB-first (new bit into [7], shift right) and increment the count. After the 8th edge -> PARITY.
  - PARITY: on edge, set status bit0 = PARITY_EN & (data != ~^byte) -> STOP.
  - STOP: on edge, set status bit1 = ~data -> PUSH.
  - PUSH: one cycle; write {status, byte} to the FIFO -> IDLE.
  - Illegal encodings -> IDLE.
- READ_ENABLE gates only the start in IDLE. Deasserting it mid-frame does not abort the frame.
- Latency: stop edge flag at cycle T; PUSH at T+1; EMPTY=0 and the head is valid at T+2.
- FIFO: first-word-fall-through, so head outputs are valid whenever EMPTY=0.
  - POP advances the read pointer at the next edge.
  - Push while FULL with no POP: the byte is dropped and OVERFLOW is set, cleared only by reset.
  - Push and POP in the same cycle: both take effect and LEVEL is unchanged, including when FULL.
  - Pointers wrap modulo FIFO_DEPTH.
- When EMPTY, BYTE_READ and BYTE_ERROR_CODE hold the last-read entry value. Consumers must not rely on this.
- Errored bytes are still pushed; the consumer decides whether to use them.

Decomposition:
- Package ps2_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP, PUSH)
  - status bit index constants (ERR_PARITY=0, ERR_STOP=1)
  - frame length constant (11)
- Sub-module sync_fifo (WIDTH=10, DEPTH=FIFO_DEPTH) holds the FIFO storage, pointers, LEVEL/FULL/EMPTY and the simultaneous push/pop rule. The synchroniser, filter, timeout and FSM stay in ps2_rx_fifo.

Test Plan:
- Bench settings: CLK 50 MHz, PS/2 clock period 80 us, FILTER_LEN=8. Send frame 0xA5 with parity 1 and stop 1 -> EMPTY falls at T+2, BYTE_READ=8'hA5, BYTE_ERROR_CODE=00, LEVEL=1; POP -> EMPTY=1.
- Send 0x08 with parity 1 (wrong) and stop 0 -> head 8'h08, code 2'b11. Repeat with PARITY_EN=0 -> code 2'b10.
- Inject 3-cycle low glitches on CLK_MOUSE_IN mid-frame, then send 0x3C -> glitches ignored, head 8'h3C, code 00.
- With TIMEOUT_US=2000, send a start bit plus 4 data bits and stall -> TIMEOUT pulses exactly once about 100000 cycles after the last edge; LEVEL stays 0. The next full frame 0x11 is received correctly.
- FIFO_DEPTH=4, no POP: send bytes 0x01..0x05 -> after the 4th, FULL=1, LEVEL=4; the 5th sets OVERFLOW=1 and the contents are 01,02,03,04. With POP asserted in the PUSH cycle while FULL, LEVEL stays 4 and 0x05 is stored.
- READ_ENABLE=0 at the start bit -> frame ignored. READ_ENABLE dropped after the start bit -> byte still received. RESET low mid-frame -> all outputs at reset values, partial byte discarded.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    PUSH   = 3'd4
  } ps2_state_e;

  localparam int ERR_PARITY = 0;
  localparam int ERR_STOP   = 1;
  localparam int FRAME_BITS = 11;
  // start, parity and stop surround the data bits
  localparam int DATA_BITS  = FRAME_BITS - 3;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head entry. A push and a pop
// in the same cycle both take effect, even when the FIFO is full.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             empty_q, full_q, overflow_q, overflow_d;
  logic             do_push_s, do_pop_s;

  // Next pointers/level; the head is reloaded from the entry that will sit at
  // the read pointer, bypassing the write when that slot is being filled now.
  always_comb begin
    do_pop_s   = pop_i && (level_q != '0);
    do_push_s  = push_i && ((level_q != FULL_LVL) || do_pop_s);
    rd_ptr_d   = do_pop_s  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = do_push_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    overflow_d = overflow_q | (push_i & ~do_push_s);
    if (do_push_s && !do_pop_s) begin
      level_d = level_q + 1'b1;
    end else if (do_pop_s && !do_push_s) begin
      level_d = level_q - 1'b1;
    end else begin
      level_d = level_q;
    end
    if (level_d == '0) begin
      head_d = head_q;
    end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      empty_q    <= (level_d == '0);
      full_q     <= (level_d == FULL_LVL);
      overflow_q <= overflow_d;
    end
  end

  assign rdata_o    = head_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: line synchronisers, clock glitch filter, frame
// FSM with inactivity timeout, and a FIFO of received bytes with error status.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PARITY_EN   = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CLK_MOUSE_IN,
  input  logic                        DATA_MOUSE_IN,
  input  logic                        READ_ENABLE,
  input  logic                        POP,
  output logic [7:0]                  BYTE_READ,
  output logic [1:0]                  BYTE_ERROR_CODE,
  output logic                        EMPTY,
  output logic                        FULL,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL,
  output logic                        OVERFLOW,
  output logic                        TIMEOUT
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FL_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [2:0]    CNT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d, filt_prev_q;
  logic          edge_s, bit_s, push_s;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    status_q, status_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q, timeout_d;
  logic [9:0]    head_s;

  assign edge_s = filt_prev_q & ~filt_clk_q;
  assign bit_s  = data_sync_q[1];

  // The filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_clk_d = filt_clk_q;
    if (clk_sync_q[1] == filt_clk_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FL_LAST) begin
      filt_clk_d = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // Frame FSM; the inactivity timeout overrides whatever the state decided.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    status_d  = status_q;
    timeout_d = 1'b0;
    push_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_s && !bit_s && READ_ENABLE) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          status_d  = 2'b00;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (edge_s) begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == CNT_LAST) ? PARITY : DATA;
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (edge_s) begin
          status_d[ERR_PARITY] = (PARITY_EN != 0) && (bit_s != ~^shift_q);
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (edge_s) begin
          status_d[ERR_STOP] = ~bit_s;
          state_d = PUSH;
        end else begin
          state_d = STOP;
        end
      end
      PUSH: begin
        push_s  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == IDLE) || edge_s) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d  = '0;
      state_d   = IDLE;
      timeout_d = 1'b1;
      push_s    = 1'b0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      status_q    <= 2'b00;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], CLK_MOUSE_IN};
      data_sync_q <= {data_sync_q[0], DATA_MOUSE_IN};
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      filt_prev_q <= filt_clk_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      status_q    <= status_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .push_i     (push_s),
    .wdata_i    ({status_q, shift_q}),
    .pop_i      (POP),
    .rdata_o    (head_s),
    .empty_o    (EMPTY),
    .full_o     (FULL),
    .level_o    (LEVEL),
    .overflow_o (OVERFLOW)
  );

  assign BYTE_READ       = head_s[7:0];
  assign BYTE_ERROR_CODE = head_s[9:8];
  assign TIMEOUT         = timeout_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: two instances (parity checked / ignored) share the
// PS/2 lines and are compared against a queue-based reference model.
module tb_ps2_rx_fifo;

  localparam int CLK_FREQ_HZ = 1000000;
  localparam int TIMEOUT_US  = 200;
  localparam int TO_CYC      = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
  localparam int FILTER_LEN  = 8;
  localparam int DEPTH       = 4;
  localparam int HALF        = 24;
  localparam int LW          = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n, ps2_clk, ps2_data, rd_en, pop;
  logic [7:0] byte1, byte2;
  logic [1:0] code1, code2;
  logic empty1, empty2, full1, full2, ovf1, ovf2, to1, to2;
  logic [LW-1:0] level1, level2;
  logic [5:0] st1, st2;
  logic [9:0] hd1, hd2;

  int checks = 0, errors = 0;
  int cyc = 0, to_p1 = 0, to_p2 = 0, last_to_cyc = 0, last_fall_cyc = 0, lat = 0;
  logic [9:0] mq[$];
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .TIMEOUT_US(TIMEOUT_US), .FILTER_LEN(FILTER_LEN),
                .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) dut (
    .CLK(clk), .RESET(rst_n), .CLK_MOUSE_IN(ps2_clk), .DATA_MOUSE_IN(ps2_data),
    .READ_ENABLE(rd_en), .POP(pop), .BYTE_READ(byte1), .BYTE_ERROR_CODE(code1),
    .EMPTY(empty1), .FULL(full1), .LEVEL(level1), .OVERFLOW(ovf1), .TIMEOUT(to1));

  ps2_rx_fifo #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .TIMEOUT_US(TIMEOUT_US), .FILTER_LEN(FILTER_LEN),
                .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) dut_np (
    .CLK(clk), .RESET(rst_n), .CLK_MOUSE_IN(ps2_clk), .DATA_MOUSE_IN(ps2_data),
    .READ_ENABLE(rd_en), .POP(pop), .BYTE_READ(byte2), .BYTE_ERROR_CODE(code2),
    .EMPTY(empty2), .FULL(full2), .LEVEL(level2), .OVERFLOW(ovf2), .TIMEOUT(to2));

  assign st1 = {empty1, full1, level1, ovf1};
  assign st2 = {empty2, full2, level2, ovf2};
  assign hd1 = {code1, byte1};
  assign hd2 = {code2, byte2};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (to1 === 1'b1) begin
      to_p1       <= to_p1 + 1;
      last_to_cyc <= cyc;
    end
    if (to2 === 1'b1) to_p2 <= to_p2 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void model_push(input logic [7:0] b, input logic pbit, input logic sbit);
    logic [9:0] e;
    e = {~sbit, (pbit != ~^b), b};
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovf = 1'b1;
  endfunction

  function automatic logic [5:0] exp_status();
    int n;
    n = mq.size();
    return {(n == 0), (n == DEPTH), LW'(n), m_ovf};
  endfunction

  function automatic logic [9:0] np_head(input logic [9:0] e);
    return {e[9], 1'b0, e[7:0]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(4); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(HALF/2 - 7);
    end else begin
      wait_cyc(HALF/2);
    end
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF/2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic sbit, input bit glitch);
    logic [10:0] f;
    f = {sbit, pbit, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], glitch && (i % 3 == 1));
  endtask

  task automatic do_pop();
    pop = 1'b1; wait_cyc(1); pop = 1'b0; wait_cyc(1);
    if (mq.size() != 0) mq.delete(0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b1; pop = 1'b0;
    wait_cyc(5); rst_n = 1'b1; wait_cyc(2);
    checks++;
    if (st1 !== 6'b100000 || st2 !== 6'b100000) begin
      errors++; $display("FAIL reset_status got %b/%b want 100000", st1, st2);
    end
    checks++;
    if (hd1 !== 10'h000 || hd2 !== 10'h000 || to1 !== 1'b0) begin
      errors++; $display("FAIL reset_head got %h/%h to=%b want 000 to=0", hd1, hd2, to1);
    end
  endtask

  task automatic test_latency();
    logic [10:0] f;
    int k;
    f = {1'b1, 1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
    ps2_data = 1'b1; wait_cyc(HALF/2); ps2_clk = 1'b0; last_fall_cyc = cyc;
    k = 0;
    while (empty1 && k < 40) begin wait_cyc(1); k++; end
    wait_cyc(HALF - k); ps2_clk = 1'b1; wait_cyc(HALF/2);
    lat = k;
    model_push(8'hA5, 1'b1, 1'b1);
    checks++;
    if (k < FILTER_LEN + 3 || k > FILTER_LEN + 5) begin
      errors++; $display("FAIL a5_latency got %0d cycles want %0d..%0d", k, FILTER_LEN + 3, FILTER_LEN + 5);
    end
    checks++;
    if (hd1 !== 10'h0A5 || hd2 !== 10'h0A5 || st1 !== exp_status()) begin
      errors++; $display("FAIL a5_head got %h/%h st %b want 0a5 st %b", hd1, hd2, st1, exp_status());
    end
    do_pop();
    checks++;
    if (st1 !== exp_status() || st2 !== exp_status()) begin
      errors++; $display("FAIL a5_pop got %b/%b want %b", st1, st2, exp_status());
    end
  endtask

  task automatic test_errors();
    send_frame(8'h08, 1'b1, 1'b0, 1'b0);
    model_push(8'h08, 1'b1, 1'b0);
    checks++;
    if (hd1 !== mq[0] || hd1 !== 10'h308) begin
      errors++; $display("FAIL err_code_par got %h want %h", hd1, mq[0]);
    end
    checks++;
    if (hd2 !== np_head(mq[0]) || hd2 !== 10'h208) begin
      errors++; $display("FAIL err_code_nopar got %h want %h", hd2, np_head(mq[0]));
    end
    do_pop();
  endtask

  task automatic test_glitch();
    int p0;
    p0 = to_p1;
    send_frame(8'h3C, ~^8'h3C, 1'b1, 1'b1);
    model_push(8'h3C, ~^8'h3C, 1'b1);
    checks++;
    if (hd1 !== 10'h03C || hd2 !== 10'h03C || st1 !== exp_status() || to_p1 != p0) begin
      errors++; $display("FAIL glitch got %h/%h st %b to %0d want 03c st %b to %0d",
                         hd1, hd2, st1, to_p1, exp_status(), p0);
    end
    do_pop();
  endtask

  task automatic test_timeout();
    int p1, p2, k, d;
    logic [7:0] b;
    logic [10:0] f;
    p1 = to_p1; p2 = to_p2;
    b = 8'($urandom);
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 5; i++) ps2_bit(f[i], 1'b0);
    k = 0;
    while (to_p1 == p1 && k < 400) begin wait_cyc(1); k++; end
    d = last_to_cyc - last_fall_cyc;
    checks++;
    if (to_p1 == p1 || d < TO_CYC || d > TO_CYC + FILTER_LEN + 12) begin
      errors++; $display("FAIL timeout_delay got %0d pulses %0d want %0d..%0d", d, to_p1 - p1, TO_CYC, TO_CYC + FILTER_LEN + 12);
    end
    wait_cyc(300);
    checks++;
    if (to_p1 != p1 + 1 || to_p2 != p2 + 1 || st1 !== exp_status()) begin
      errors++; $display("FAIL timeout_once got pulses %0d/%0d st %b want 1/1 st %b", to_p1 - p1, to_p2 - p2, st1, exp_status());
    end
    send_frame(8'h11, ~^8'h11, 1'b1, 1'b0);
    model_push(8'h11, ~^8'h11, 1'b1);
    checks++;
    if (hd1 !== 10'h011 || st1 !== exp_status()) begin
      errors++; $display("FAIL timeout_next got %h st %b want 011 st %b", hd1, st1, exp_status());
    end
    do_pop();
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    logic [10:0] f;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, ~^b, 1'b1, 1'b0);
      model_push(b, ~^b, 1'b1);
      checks++;
      if (st1 !== exp_status() || st2 !== exp_status() || (i == 4 && (full1 !== 1'b1 || level1 !== 3'd4))) begin
        errors++; $display("FAIL fill_%0d got %b/%b want %b", i, st1, st2, exp_status());
      end
    end
    checks++;
    if (ovf1 !== 1'b1) begin
      errors++; $display("FAIL overflow_flag got %b want 1", ovf1);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (hd1 !== mq[0] || hd1 !== {2'b00, 8'(i)}) begin
        errors++; $display("FAIL drain_%0d got %h want %h", i, hd1, mq[0]);
      end
      do_pop();
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, ~^b, 1'b1, 1'b0);
      model_push(b, ~^b, 1'b1);
    end
    f = {1'b1, ~^8'h05, 8'h05, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i], 1'b0);
    ps2_data = 1'b1; wait_cyc(HALF/2); ps2_clk = 1'b0;
    wait_cyc(lat - 1); pop = 1'b1; wait_cyc(1); pop = 1'b0;
    wait_cyc(HALF - lat); ps2_clk = 1'b1; wait_cyc(HALF/2);
    mq.delete(0);
    model_push(8'h05, ~^8'h05, 1'b1);
    checks++;
    if (st1 !== exp_status() || level1 !== 3'd4) begin
      errors++; $display("FAIL pushpop_full got %b want %b", st1, exp_status());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hd1 !== mq[0] || hd2 !== np_head(mq[0])) begin
        errors++; $display("FAIL pushpop_drain_%0d got %h/%h want %h", i, hd1, hd2, mq[0]);
      end
      do_pop();
    end
  endtask

  task automatic test_read_enable();
    logic [7:0] b;
    logic [10:0] f;
    rd_en = 1'b0;
    b = 8'($urandom);
    send_frame(b, ~^b, 1'b1, 1'b0);
    rd_en = 1'b1;
    checks++;
    if (st1 !== exp_status() || st2 !== exp_status()) begin
      errors++; $display("FAIL re_ignored got %b/%b want %b", st1, st2, exp_status());
    end
    b = 8'($urandom);
    f = {1'b1, ~^b, b, 1'b0};
    ps2_bit(f[0], 1'b0);
    rd_en = 1'b0;
    for (int i = 1; i < 11; i++) ps2_bit(f[i], 1'b0);
    rd_en = 1'b1;
    model_push(b, ~^b, 1'b1);
    checks++;
    if (st1 !== exp_status() || hd1 !== mq[0]) begin
      errors++; $display("FAIL re_dropped_mid got %b %h want %b %h", st1, hd1, exp_status(), mq[0]);
    end
    do_pop();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic pbit, sbit;
    int np;
    for (int n = 0; n < 14; n++) begin
      b    = 8'($urandom);
      pbit = (~^b) ^ ($urandom_range(0, 3) == 0);
      sbit = ($urandom_range(0, 3) != 0);
      send_frame(b, pbit, sbit, 1'b0);
      model_push(b, pbit, sbit);
      np = $urandom_range(0, 2);
      for (int j = 0; j < np; j++) do_pop();
      checks++;
      if (st1 !== exp_status() || st2 !== exp_status()) begin
        errors++; $display("FAIL rand_status_%0d got %b/%b want %b", n, st1, st2, exp_status());
      end
      if (mq.size() != 0) begin
        checks++;
        if (hd1 !== mq[0] || hd2 !== np_head(mq[0])) begin
          errors++; $display("FAIL rand_head_%0d got %h/%h want %h/%h", n, hd1, hd2, mq[0], np_head(mq[0]));
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    logic [10:0] f;
    int p1;
    b = 8'($urandom);
    send_frame(b, ~^b, 1'b1, 1'b0);
    model_push(b, ~^b, 1'b1);
    b = 8'($urandom);
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < 4; i++) ps2_bit(f[i], 1'b0);
    ps2_data = 1'b0; wait_cyc(HALF/2); ps2_clk = 1'b0; wait_cyc(HALF/2);
    rst_n = 1'b0; wait_cyc(3);
    ps2_clk = 1'b1; ps2_data = 1'b1; wait_cyc(3);
    rst_n = 1'b1; wait_cyc(2);
    mq.delete(); m_ovf = 1'b0;
    p1 = to_p1;
    checks++;
    if (st1 !== 6'b100000 || st2 !== 6'b100000 || hd1 !== 10'h000 || hd2 !== 10'h000) begin
      errors++; $display("FAIL midreset_outputs got %b %h / %b %h want 100000 000", st1, hd1, st2, hd2);
    end
    wait_cyc(TO_CYC + 50);
    checks++;
    if (to_p1 != p1 || st1 !== exp_status()) begin
      errors++; $display("FAIL midreset_partial got pulses %0d st %b want 0 st %b", to_p1 - p1, st1, exp_status());
    end
    b = 8'($urandom);
    send_frame(b, ~^b, 1'b1, 1'b0);
    model_push(b, ~^b, 1'b1);
    checks++;
    if (st1 !== exp_status() || hd1 !== mq[0] || hd2 !== np_head(mq[0])) begin
      errors++; $display("FAIL midreset_next got %b %h want %b %h", st1, hd1, exp_status(), mq[0]);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_errors();
    test_glitch();
    test_timeout();
    test_overflow();
    test_read_enable();
    test_random();
    test_reset_midframe();
    checks++;
    if (to_p1 != 1 || to_p2 != 1) begin
      errors++; $display("FAIL timeout_total got %0d/%0d want 1/1", to_p1, to_p2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
